// File: rtl/toeplitz_pkg.sv
// Shared definitions for the Toeplitz extractor readout path: block size,
// the word type and the width of the partial-word bit counter.
package toeplitz_pkg;

    localparam int BS = 64;

    typedef logic [BS-1:0] word_t;

    function automatic int bitcnt_width(input int w);
        return (w > 2) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/word_fifo.sv
// Small power-of-two word FIFO with read/write pointers and an occupancy count.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module word_fifo #(
    parameter int W     = 64,
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push,
    input  logic [W-1:0]                 push_data,
    input  logic                         pop,
    output logic [W-1:0]                 rdata,
    output logic                         full,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int AW = (DEPTH > 2) ? $clog2(DEPTH) : 1;
    localparam int CNTW = $clog2(DEPTH + 1);

    logic [W-1:0]    mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNTW-1:0] count_q, count_d;
    logic            empty;
    logic            pop_ok;
    logic            push_ok;

    always_comb begin
        empty    = (count_q == '0);
        full     = (count_q == CNTW'(DEPTH));
        pop_ok   = pop && !empty;
        push_ok  = push && (!full || pop_ok);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (push_ok && !pop_ok) begin
            count_d = count_q + CNTW'(1);
        end else if (pop_ok && !push_ok) begin
            count_d = count_q - CNTW'(1);
        end
        // Head is forced to zero while empty so the output has a defined reset value.
        rdata = empty ? '0 : mem_q[rd_ptr_q];
        count = count_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/bit_deserializer.sv
// Reassembles the serial qbit/qbiten stream MSB first into W-bit words and
// queues them toward the host with valid/ready; dropped words set a sticky flag.
module bit_deserializer
    import toeplitz_pkg::*;
#(
    parameter int W     = BS,
    parameter int DEPTH = 2
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        qbit,
    input  logic                        qbiten,
    input  logic                        sync,
    output logic [W-1:0]                word,
    output logic                        wvalid,
    input  logic                        wready,
    output logic                        overflow,
    output logic [bitcnt_width(W)-1:0]  bitcnt
);

    localparam int CW   = bitcnt_width(W);
    localparam int CNTW = $clog2(DEPTH + 1);

    logic [W-1:0]    acc_q, acc_d;
    logic [CW-1:0]   bitcnt_q, bitcnt_d;
    logic            overflow_q, overflow_d;
    logic [W-1:0]    next_word;
    logic            push_req;
    logic            pop;
    logic            fifo_full;
    logic [CNTW-1:0] fifo_count;

    always_comb begin
        acc_d      = acc_q;
        bitcnt_d   = bitcnt_q;
        overflow_d = overflow_q;
        push_req   = 1'b0;
        next_word  = {acc_q[W-2:0], qbit};
        wvalid     = (fifo_count != '0);
        pop        = wvalid && wready;
        // sync wins over a bit arriving in the same cycle
        if (sync) begin
            acc_d    = '0;
            bitcnt_d = '0;
        end else if (qbiten) begin
            acc_d = next_word;
            if (bitcnt_q == CW'(W - 1)) begin
                bitcnt_d = '0;
                push_req = 1'b1;
            end else begin
                bitcnt_d = bitcnt_q + CW'(1);
            end
        end
        if (push_req && fifo_full && !pop) begin
            overflow_d = 1'b1;
        end
        overflow = overflow_q;
        bitcnt   = bitcnt_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q      <= '0;
            bitcnt_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            acc_q      <= acc_d;
            bitcnt_q   <= bitcnt_d;
            overflow_q <= overflow_d;
        end
    end

    word_fifo #(
        .W     (W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push_req),
        .push_data (next_word),
        .pop       (pop),
        .rdata     (word),
        .full      (fifo_full),
        .count     (fifo_count)
    );

endmodule

// File: tb/tb_bit_deserializer.sv
// Self-checking bench for bit_deserializer (W=64, DEPTH=2): directed scenarios
// plus randomized traffic compared against a queue-based reference model.
module tb_bit_deserializer;

    localparam int W     = 64;
    localparam int DEPTH = 2;

    logic         clk = 1'b0;
    logic         reset;
    logic         qbit;
    logic         qbiten;
    logic         sync;
    logic         wready;
    logic [W-1:0] word;
    logic         wvalid;
    logic         overflow;
    logic [5:0]   bitcnt;

    int checks = 0;
    int errors = 0;

    // Reference model: bits of the partial word in arrival order, queued words, sticky flag.
    bit           bits_m[$];
    logic [W-1:0] fifo_m[$];
    bit           ovf_m;

    always #5 clk = ~clk;

    bit_deserializer #(.W(W), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .reset    (reset),
        .qbit     (qbit),
        .qbiten   (qbiten),
        .sync     (sync),
        .word     (word),
        .wvalid   (wvalid),
        .wready   (wready),
        .overflow (overflow),
        .bitcnt   (bitcnt)
    );

    // Drive one cycle of inputs, advance the model across the edge, sample #1 later.
    task automatic drive(input logic b, input logic en, input logic s, input logic rdy);
        logic [W-1:0] w;
        bit           do_push;
        bit           do_pop;
        qbit   = b;
        qbiten = en;
        sync   = s;
        wready = rdy;
        @(posedge clk);
        do_push = 1'b0;
        w = '0;
        if (reset) begin
            bits_m.delete();
            fifo_m.delete();
            ovf_m = 1'b0;
        end else begin
            do_pop = (fifo_m.size() != 0) && rdy;
            if (s) begin
                bits_m.delete();
            end else if (en) begin
                bits_m.push_back(b);
                if (bits_m.size() == W) begin
                    for (int i = 0; i < W; i++) w[W-1-i] = bits_m[i];
                    bits_m.delete();
                    do_push = 1'b1;
                end
            end
            if (do_pop) void'(fifo_m.pop_front());
            if (do_push) begin
                if (fifo_m.size() < DEPTH) fifo_m.push_back(w);
                else ovf_m = 1'b1;
            end
        end
        #1;
    endtask

    task automatic send_word(input logic [W-1:0] w, input logic rdy);
        logic [W-1:0] v;
        v = w;
        for (int i = W - 1; i >= 0; i--) drive(v[i], 1'b1, 1'b0, rdy);
    endtask

    task automatic test_reset;
        reset = 1'b1;
        drive(1'b1, 1'b1, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        checks++;
        if (word !== '0) begin
            errors++;
            $display("FAIL reset_word got %h want 0", word);
        end
        for (int c = 0; c < 10; c++) begin
            drive(1'($urandom), 1'b0, 1'b0, 1'($urandom));
            checks++;
            if (wvalid !== 1'b0 || overflow !== 1'b0 || bitcnt !== 6'd0) begin
                errors++;
                $display("FAIL reset_idle cyc %0d got v=%b o=%b n=%0d want 0/0/0",
                         c, wvalid, overflow, bitcnt);
            end
        end
    endtask

    task automatic test_single_word;
        logic [W-1:0] v;
        int           vcount;
        v = 64'h0123_4567_89AB_CDEF;
        vcount = 0;
        for (int i = W - 1; i >= 0; i--) begin
            drive(v[i], 1'b1, 1'b0, 1'b1);
            if (wvalid === 1'b1) vcount++;
        end
        checks++;
        if (wvalid !== 1'b1 || word !== 64'h0123_4567_89AB_CDEF || vcount != 1) begin
            errors++;
            $display("FAIL single_word got v=%b w=%h early=%0d want 1 0123456789abcdef",
                     wvalid, word, vcount - 1);
        end
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        checks++;
        if (wvalid !== 1'b0 || bitcnt !== 6'd0) begin
            errors++;
            $display("FAIL single_word_drop got v=%b n=%0d want 0 0", wvalid, bitcnt);
        end
    endtask

    task automatic test_gapped;
        logic [W-1:0] v;
        v = 64'h0123_4567_89AB_CDEF;
        for (int i = W - 1; i >= 0; i--) begin
            drive(v[i], 1'b1, 1'b0, 1'b1);
            checks++;
            if (bitcnt !== 6'((W - i) % W)) begin
                errors++;
                $display("FAIL gapped_cnt bit %0d got %0d want %0d", i, bitcnt, (W - i) % W);
            end
            if (i == 0) begin
                checks++;
                if (wvalid !== 1'b1 || word !== 64'h0123_4567_89AB_CDEF) begin
                    errors++;
                    $display("FAIL gapped_word got v=%b w=%h want 1 0123456789abcdef",
                             wvalid, word);
                end
            end
            drive(1'($urandom), 1'b0, 1'b0, 1'b1);
        end
        checks++;
        if (wvalid !== 1'b0 || bitcnt !== 6'd0) begin
            errors++;
            $display("FAIL gapped_end got v=%b n=%0d want 0 0", wvalid, bitcnt);
        end
    endtask

    task automatic test_backpressure;
        send_word(64'h1, 1'b0);
        checks++;
        if (wvalid !== 1'b1 || word !== 64'h1 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL bp_a got v=%b w=%h o=%b want 1 1 0", wvalid, word, overflow);
        end
        send_word(64'h2, 1'b0);
        checks++;
        if (word !== 64'h1 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL bp_b got w=%h o=%b want 1 0", word, overflow);
        end
        send_word(64'h3, 1'b0);
        checks++;
        if (word !== 64'h1 || overflow !== 1'b1 || wvalid !== 1'b1) begin
            errors++;
            $display("FAIL bp_c got v=%b w=%h o=%b want 1 1 1", wvalid, word, overflow);
        end
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        checks++;
        if (wvalid !== 1'b1 || word !== 64'h2) begin
            errors++;
            $display("FAIL bp_pop1 got v=%b w=%h want 1 2", wvalid, word);
        end
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        checks++;
        if (wvalid !== 1'b0 || overflow !== 1'b1) begin
            errors++;
            $display("FAIL bp_pop2 got v=%b o=%b want 0 1", wvalid, overflow);
        end
    endtask

    task automatic test_sync;
        for (int i = 0; i < 10; i++) drive(1'($urandom), 1'b1, 1'b0, 1'b1);
        checks++;
        if (bitcnt !== 6'd10) begin
            errors++;
            $display("FAIL sync_pre got %0d want 10", bitcnt);
        end
        // a bit coincident with sync must be thrown away
        drive(1'b1, 1'b1, 1'b1, 1'b1);
        checks++;
        if (bitcnt !== 6'd0 || wvalid !== 1'b0) begin
            errors++;
            $display("FAIL sync_clear got n=%0d v=%b want 0 0", bitcnt, wvalid);
        end
        send_word(64'hFFFF_0000_FFFF_0000, 1'b1);
        checks++;
        if (wvalid !== 1'b1 || word !== 64'hFFFF_0000_FFFF_0000 || bitcnt !== 6'd0) begin
            errors++;
            $display("FAIL sync_word got v=%b w=%h n=%0d want 1 ffff0000ffff0000 0",
                     wvalid, word, bitcnt);
        end
        drive(1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_reset_midword;
        send_word(64'hA5A5_5A5A_0F0F_F0F0, 1'b0);
        for (int i = 0; i < 20; i++) drive(1'($urandom), 1'b1, 1'b0, 1'b0);
        reset = 1'b1;
        drive(1'b1, 1'b1, 1'b1, 1'b1);
        reset = 1'b0;
        checks++;
        if (wvalid !== 1'b0 || overflow !== 1'b0 || bitcnt !== 6'd0 || word !== '0) begin
            errors++;
            $display("FAIL reset_mid got v=%b o=%b n=%0d w=%h want 0 0 0 0",
                     wvalid, overflow, bitcnt, word);
        end
    endtask

    task automatic test_random(input int cycles, input int rdy_pct);
        int bad;
        bad = 0;
        for (int c = 0; c < cycles; c++) begin
            drive(1'($urandom), ($urandom_range(99) < 80), ($urandom_range(299) == 0),
                  ($urandom_range(99) < rdy_pct));
            checks++;
            if (wvalid !== (fifo_m.size() != 0) || overflow !== ovf_m ||
                bitcnt !== 6'(bits_m.size()) ||
                ((fifo_m.size() != 0) && word !== fifo_m[0])) begin
                errors++;
                bad++;
                if (bad <= 5)
                    $display("FAIL random cyc %0d got v=%b w=%h o=%b n=%0d want v=%b o=%b n=%0d w=%h",
                             c, wvalid, word, overflow, bitcnt, fifo_m.size() != 0, ovf_m,
                             bits_m.size(), (fifo_m.size() != 0) ? fifo_m[0] : 64'h0);
            end
        end
    endtask

    initial begin
        reset  = 1'b1;
        qbit   = 1'b0;
        qbiten = 1'b0;
        sync   = 1'b0;
        wready = 1'b0;
        bits_m.delete();
        fifo_m.delete();
        ovf_m  = 1'b0;
        test_reset();
        test_single_word();
        test_gapped();
        test_backpressure();
        test_sync();
        test_reset_midword();
        test_random(3000, 100);
        test_random(6000, 3);
        reset = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        test_random(6000, 40);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
